// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: owner state encoding and port selectors.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// One requester port of the RAM arbiter: request/lock/payload toward the arbiter,
// grant and read-valid back to the requester.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  lock;
  logic                  gnt;
  logic                  rvalid;

  modport master (output req, we, addr, wdata, lock, input gnt, rvalid);
  modport slave  (input req, we, addr, wdata, lock, output gnt, rvalid);

endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between ports A and B,
// with a per-port lock for atomic read-modify-write and a registered read-valid strobe.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_port_arbiter_if.slave     port_a,
  ram_port_arbiter_if.slave     port_b,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  owner_t                owner_q, owner_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic                  rvalid_a_q, rvalid_a_d;
  logic                  rvalid_b_q, rvalid_b_d;

  logic                  ok_a, ok_b;
  logic                  grant;
  logic                  sel;
  logic                  gnt_a, gnt_b;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_NONE;
      last_q      <= SEL_B;
      hold_addr_q <= '0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      hold_addr_q <= hold_addr_d;
      rvalid_a_q  <= rvalid_a_d;
      rvalid_b_q  <= rvalid_b_d;
    end
  end

  // Arbitration and next-state; grants are suppressed while reset is held
  always_comb begin
    grant       = 1'b0;
    sel         = SEL_A;
    owner_d     = owner_q;
    last_d      = last_q;
    hold_addr_d = hold_addr_q;
    rvalid_a_d  = 1'b0;
    rvalid_b_d  = 1'b0;
    ok_a        = port_a.req && (owner_q != OWN_B);
    ok_b        = port_b.req && (owner_q != OWN_A);

    if (rst_n) begin
      if (ok_a && ok_b) begin
        grant = 1'b1;
        sel   = (last_q == SEL_A) ? SEL_B : SEL_A;
      end else if (ok_a) begin
        grant = 1'b1;
        sel   = SEL_A;
      end else if (ok_b) begin
        grant = 1'b1;
        sel   = SEL_B;
      end
    end

    if (grant) begin
      last_d = sel;
      if (sel == SEL_A) begin
        owner_d     = port_a.lock ? OWN_A : OWN_NONE;
        hold_addr_d = port_a.addr;
        rvalid_a_d  = !port_a.we;
      end else begin
        owner_d     = port_b.lock ? OWN_B : OWN_NONE;
        hold_addr_d = port_b.addr;
        rvalid_b_d  = !port_b.we;
      end
    end
  end

  // Grant strobes and RAM drive; idle cycles park the held address so ram_dout stays stable
  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    ram_we   = 1'b0;
    ram_addr = hold_addr_q;
    ram_din  = '0;
    if (grant) begin
      if (sel == SEL_A) begin
        gnt_a    = 1'b1;
        ram_we   = port_a.we;
        ram_addr = port_a.addr;
        ram_din  = port_a.wdata;
      end else begin
        gnt_b    = 1'b1;
        ram_we   = port_b.we;
        ram_addr = port_b.addr;
        ram_din  = port_b.wdata;
      end
    end
  end

  assign port_a.gnt    = gnt_a;
  assign port_b.gnt    = gnt_b;
  assign port_a.rvalid = rvalid_a_q;
  assign port_b.rvalid = rvalid_b_q;
  assign rdata         = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural registered-address RAM.
module tb_ram_port_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  int checks   = 0;
  int failures = 0;

  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_a ();
  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_b ();

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .port_a   (if_a),
    .port_b   (if_b),
    .rdata    (rdata),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM: registered address, write-first
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] addr_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    addr_q <= ram_addr;
  end
  assign ram_dout = mem[addr_q];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic lock);
    if_a.req = req; if_a.we = we; if_a.addr = addr; if_a.wdata = wdata; if_a.lock = lock;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic lock);
    if_b.req = req; if_b.we = we; if_b.addr = addr; if_b.wdata = wdata; if_b.lock = lock;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    mem[12'h001] = 8'h11;
    mem[12'h002] = 8'h22;
    mem[12'h010] = 8'h40;
    mem[12'h0FF] = 8'h33;

    // Reset with both ports requesting
    rst_n = 1'b0;
    drive_a(1'b1, 1'b0, 12'h001, 8'h00, 1'b0);
    drive_b(1'b1, 1'b0, 12'h002, 8'h00, 1'b0);
    @(negedge clk); #1;
    check("rst_gnt_a",    32'(if_a.gnt),    32'd0);
    check("rst_gnt_b",    32'(if_b.gnt),    32'd0);
    check("rst_rvalid_a", 32'(if_a.rvalid), 32'd0);
    check("rst_rvalid_b", 32'(if_b.rvalid), 32'd0);
    check("rst_ram_we",   32'(ram_we),      32'd0);
    check("rst_ram_addr", 32'(ram_addr),    32'd0);
    check("rst_ram_din",  32'(ram_din),     32'd0);

    // Release: A wins the first tie
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_gnt_a", 32'(if_a.gnt), 32'd1);
    check("first_gnt_b", 32'(if_b.gnt), 32'd0);
    check("first_addr",  32'(ram_addr), 32'h001);

    // Fairness: alternating grants, rvalid one cycle behind
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("fair_rvalid_a", 32'(if_a.rvalid), (k % 2 == 1) ? 32'd1 : 32'd0);
      check("fair_rvalid_b", 32'(if_b.rvalid), (k % 2 == 1) ? 32'd0 : 32'd1);
      check("fair_rdata",    32'(rdata),       (k % 2 == 1) ? 32'h11 : 32'h22);
      #1;
      check("fair_gnt_a", 32'(if_a.gnt), (k % 2 == 1) ? 32'd0 : 32'd1);
      check("fair_gnt_b", 32'(if_b.gnt), (k % 2 == 1) ? 32'd1 : 32'd0);
    end

    // A writes 0x5A to 0x123
    @(negedge clk);
    check("fair_last_rvalid_a", 32'(if_a.rvalid), 32'd1);
    drive_b(1'b0, 1'b0, 12'h002, 8'h00, 1'b0);
    drive_a(1'b1, 1'b1, 12'h123, 8'h5A, 1'b0);
    #1;
    check("wr_gnt_a",    32'(if_a.gnt), 32'd1);
    check("wr_ram_we",   32'(ram_we),   32'd1);
    check("wr_ram_addr", 32'(ram_addr), 32'h123);
    check("wr_ram_din",  32'(ram_din),  32'h5A);

    // A reads 0x123 back
    @(negedge clk);
    check("wr_no_rvalid", 32'(if_a.rvalid), 32'd0);
    drive_a(1'b1, 1'b0, 12'h123, 8'h00, 1'b0);
    #1;
    check("rd_gnt_a",  32'(if_a.gnt), 32'd1);
    check("rd_ram_we", 32'(ram_we),   32'd0);

    // Data returns; B reads alone so the next tie favours A
    @(negedge clk);
    check("rd_rvalid_a", 32'(if_a.rvalid), 32'd1);
    check("rd_rdata",    32'(rdata),       32'h5A);
    drive_a(1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    drive_b(1'b1, 1'b0, 12'h002, 8'h00, 1'b0);
    #1;
    check("pre_lock_gnt_b", 32'(if_b.gnt), 32'd1);

    // Lock: A reads 0x010 with lock while B keeps requesting
    @(negedge clk);
    check("pre_lock_rvalid_b", 32'(if_b.rvalid), 32'd1);
    check("pre_lock_rdata",    32'(rdata),       32'h22);
    drive_a(1'b1, 1'b0, 12'h010, 8'h00, 1'b1);
    #1;
    check("lock_gnt_a", 32'(if_a.gnt), 32'd1);
    check("lock_gnt_b", 32'(if_b.gnt), 32'd0);

    @(negedge clk);
    check("lock_rvalid_a", 32'(if_a.rvalid), 32'd1);
    check("lock_rdata",    32'(rdata),       32'h40);
    drive_a(1'b0, 1'b0, 12'h010, 8'h00, 1'b1);
    #1;
    check("lock_idle_gnt_a", 32'(if_a.gnt), 32'd0);
    check("lock_idle_gnt_b", 32'(if_b.gnt), 32'd0);

    @(negedge clk);
    drive_a(1'b1, 1'b1, 12'h010, 8'h41, 1'b0);
    #1;
    check("unlock_gnt_a", 32'(if_a.gnt), 32'd1);
    check("unlock_gnt_b", 32'(if_b.gnt), 32'd0);

    @(negedge clk);
    drive_a(1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    #1;
    check("after_unlock_gnt_b", 32'(if_b.gnt), 32'd1);

    // Idle hold: A reads 0x0FF then all requests drop
    @(negedge clk);
    check("after_unlock_rvalid_b", 32'(if_b.rvalid), 32'd1);
    check("after_unlock_rdata",    32'(rdata),       32'h22);
    drive_b(1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    drive_a(1'b1, 1'b0, 12'h0FF, 8'h00, 1'b0);
    #1;
    check("hold_gnt_a", 32'(if_a.gnt), 32'd1);

    @(negedge clk);
    drive_a(1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("hold_ram_we",   32'(ram_we),      32'd0);
      check("hold_ram_addr", 32'(ram_addr),    32'h0FF);
      check("hold_ram_din",  32'(ram_din),     32'd0);
      check("hold_rdata",    32'(rdata),       32'h33);
      check("hold_rvalid_a", 32'(if_a.rvalid), (k == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end

    // Async reset while A owns via lock
    drive_a(1'b1, 1'b0, 12'h0FF, 8'h00, 1'b1);
    #1;
    check("mid_lock_gnt_a", 32'(if_a.gnt), 32'd1);

    @(negedge clk);
    drive_a(1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    drive_b(1'b1, 1'b0, 12'h002, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid_a", 32'(if_a.rvalid), 32'd0);
    check("mid_rst_gnt_b",    32'(if_b.gnt),    32'd0);
    check("mid_rst_ram_addr", 32'(ram_addr),    32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_gnt_b", 32'(if_b.gnt), 32'd1);
    check("post_rst_gnt_a", 32'(if_a.gnt), 32'd0);

    @(negedge clk);
    drive_b(1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    check("post_rst_rvalid_b", 32'(if_b.rvalid), 32'd1);
    check("post_rst_rdata",    32'(rdata),       32'h22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter that shares one single-port synchronous RAM (registered address, write-first storage, 1-cycle read latency) between ports A and B.
- Performs one RAM access per cycle, returns read data with a per-port valid strobe, and supports a lock for atomic read-modify-write sequences.
- Sits directly in front of the RAM instance. Only this block drives RAM we/addr/din.

Parameters:
ADDR_WIDTH, 12, RAM address width (depth 2**ADDR_WIDTH)
DATA_WIDTH, 8, RAM data width

Ports:
clk  in  1  system clock; all state on posedge
rst_n  in  1  reset, asynchronous assert, active-low
req_a  in  1  port A access request; held until gnt_a
we_a  in  1  port A write (1) / read (0); valid with req_a
addr_a  in  ADDR_WIDTH  port A address
wdata_a  in  DATA_WIDTH  port A write data
lock_a  in  1  port A keeps ownership after this grant
gnt_a  out  1  port A access accepted this cycle
rvalid_a  out  1  port A read data valid on rdata
req_b, we_b, addr_b, wdata_b, lock_b, gnt_b, rvalid_b  same as port A, for port B
rdata  out  DATA_WIDTH  shared read data (= ram_dout)
ram_we  out  1  to RAM we
ram_addr  out  ADDR_WIDTH  to RAM addr
ram_din  out  DATA_WIDTH  to RAM din
ram_dout  in  DATA_WIDTH  from RAM dout

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0: gnt_a/b=0, rvalid_a/b=0, ram_we=0, ram_addr=0, ram_din=0, last_grant=B (A wins first tie), owner=NONE, hold_addr=0.
- Grant is combinational in the request cycle. Same-cycle gnt and ram_* drive. At most one gnt per cycle.
- Owner state machine, states NONE/A/B:
  - NONE: single requester wins. If both request, the port != last_grant wins.
  - A: only req_a can be granted; req_b waits, gnt_b=0. Same rule for B.
  - On each grant, owner <= (lock of granted port) ? granted port : NONE. last_grant <= granted port.
  - Owner in A/B with its req low: no grant that cycle. Owner returns to NONE only when that port is granted with lock=0. If the owner never issues such a grant, ownership persists indefinitely; this is a requester protocol obligation.
- RAM drive on grant: ram_we=we_x, ram_addr=addr_x, ram_din=wdata_x. hold_addr <= addr_x.
- RAM drive with no grant: ram_we=0, ram_addr=hold_addr, ram_din=0. Holding the address keeps ram_dout stable.
- Read return: rvalid_x registered and asserted exactly 1 cycle after a read grant to x, for one cycle. rdata is valid in that cycle. Write grants produce no rvalid.
- Back-to-back: a grant is possible every cycle. A read followed by another access returns the first read data correctly because the RAM registers the address.
- Same-address write then read: the read in the next cycle returns the new data.
- Request deasserted without gnt: no effect, no state change.
- Reset asserted mid-operation: pending rvalid is dropped and owner is cleared. Requesters must re-issue.

Decomposition:
- Package ram_arb_pkg: owner_t enum {OWN_NONE, OWN_A, OWN_B}; port-select constants SEL_A=0, SEL_B=1.
- No sub-module. Arbitration, mux and return tracking fit in one module.

Test Plan:
- Reset: rst_n=0 with req_a=req_b=1 -> all outputs 0. First cycle after release: gnt_a=1.
- Fairness: both ports request reads continuously -> grants alternate A,B,A,B. rvalid_x follows each gnt_x by exactly 1 cycle.
- Write/read: A writes 0x5A to addr 0x123, then A reads 0x123 next cycle -> rvalid_a=1 with rdata=0x5A one cycle after the read grant.
- Lock: A reads 0x010 with lock_a=1, B requests throughout, A writes 0x010 with lock_a=0 two cycles later -> gnt_b=0 until the cycle after the A write, then gnt_b=1.
- Idle hold: A reads 0x0FF (data 0x33), then no requests for 5 cycles -> ram_we=0, ram_addr=0x0FF, rdata stays 0x33.
- Async reset mid-lock: A owns via lock, pull rst_n low for 1 cycle -> owner=NONE and rvalid=0. B is granted on its next request.
